truth_table_sweeper: RTL
========================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter SETTLE_W, default 8, width of the settle-delay counter.
REQ-002 Parameter NUM_IN, default 4, number of circuit inputs; the sweep covers 2**NUM_IN vectors (16 at default).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a sweep; accepted only in IDLE.
REQ-006 abort  input  1  synchronous sweep cancel.
REQ-007 expected_tt  input  16  expected truth table; bit i is the required output for vector i.
REQ-008 settle_cycles  input  SETTLE_W  wait cycles between driving a vector and sampling it.
REQ-009 circuit_out  input  1  output of the combinational NOR/NOT circuit under control.
REQ-010 in1, in2, in3, in4  output  1 each  circuit input drives; vector i gives in1=i[3], in2=i[2], in3=i[1], in4=i[0].
REQ-011 busy  output  1  high while a sweep is in progress.
REQ-012 done  output  1  one-cycle pulse at sweep completion.
REQ-013 pass  output  1  high when observed_tt equals expected_tt after the last sweep.
REQ-014 observed_tt  output  16  sampled circuit response; bit i captured for vector i.
REQ-015 mismatch_mask  output  16  observed_tt XOR expected_tt, valid when done.

Function
REQ-016 The FSM SHALL have states IDLE, SETTLE, SAMPLE, DONE.
REQ-017 IDLE with start=1 SHALL, on the next edge: set idx=0, clear observed_tt, latch expected_tt and settle_cycles, load the counter with the latched settle_cycles, and enter SETTLE.
REQ-018 in1..in4 SHALL be registered from idx and SHALL be stable throughout SETTLE and SAMPLE of each vector.
REQ-019 SETTLE SHALL decrement the counter each cycle and SHALL go to SAMPLE in the cycle after the counter reads 0; settle_cycles=0 gives exactly one SETTLE cycle.
REQ-020 SAMPLE SHALL write circuit_out into observed_tt[idx].
REQ-021 After SAMPLE, if idx<15 the FSM SHALL increment idx, reload the counter and return to SETTLE; if idx=15 it SHALL enter DONE.
REQ-022 Each vector SHALL take settle_cycles+2 cycles; a full sweep SHALL take 16*(settle_cycles+2) cycles from start acceptance to DONE entry.
REQ-023 DONE SHALL last one cycle, assert done, update pass and mismatch_mask from the final observed_tt, and then return to IDLE.
REQ-024 busy SHALL be 1 in SETTLE and SAMPLE and 0 in IDLE and DONE.
REQ-025 start while busy SHALL be ignored, with no restart and no queuing.
REQ-026 Changes to expected_tt or settle_cycles during a sweep SHALL have no effect because both are latched at start.
REQ-027 abort in any non-IDLE state SHALL go to IDLE on the next edge, with done=0, pass=0, mismatch_mask=0, in1..in4=0, and observed_tt holding partial data.
REQ-028 abort and start in the same IDLE cycle: abort SHALL win and start SHALL be dropped.
REQ-029 observed_tt, pass and mismatch_mask SHALL hold until the next accepted start or reset.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, idx=0, counter=0, in1..in4=0, busy=0, done=0, pass=0, observed_tt=0 and mismatch_mask=0, including mid-sweep.
REQ-031 After rst_n deasserts, the block SHALL wait in IDLE for start.

Structure
REQ-032 A shared package cello_sweep_pkg SHALL hold the FSM state enum, NUM_VECTORS=16 and the vector-to-input bit mapping constants.
REQ-033 The settle down-counter SHALL be a sub-module sweep_settle_timer with load, value, enable and zero-flag ports.
REQ-034 The circuit under control SHALL be instantiated outside this block and connected only through in1..in4 and circuit_out.

Verification
REQ-035 Ideal 0xB744 circuit model, expected_tt=0xB744, settle_cycles=3 -> done 80 cycles after start, pass=1, observed_tt=0xB744, mismatch_mask=0x0000.
REQ-036 circuit_out stuck at 0, expected_tt=0xB744 -> observed_tt=0x0000, mismatch_mask=0xB744, pass=0.
REQ-037 settle_cycles=0 -> done 32 cycles after start; in1..in4 step through 0000 to 1111 every 2 cycles.
REQ-038 abort during vector 5 -> IDLE next cycle, no done pulse, busy=0, observed_tt bits 0-4 valid; a new start then runs a full sweep.
REQ-039 rst_n pulsed low mid-sweep -> all outputs 0 asynchronously; start held during the busy window of a later sweep -> sweep length unchanged.

Source files
------------

// File: rtl/cello_sweep_pkg.sv
// Shared definitions for the truth-table sweeper.
// Holds the sweep FSM state encoding, the number of vectors in a full sweep,
// and the mapping from the vector index to the circuit input drives.
package cello_sweep_pkg;

    // A full sweep of a 4-input circuit covers every input combination.
    localparam int NUM_VECTORS = 16;

    // Vector index bit that drives each circuit input: in1 is the MSB.
    localparam int IN1_BIT = 3;
    localparam int IN2_BIT = 2;
    localparam int IN3_BIT = 1;
    localparam int IN4_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle-delay down-counter for the truth-table sweeper.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   load        - load the counter with load_value (takes priority over enable)
//   load_value  - value loaded on load
//   enable      - decrement by one; the count never wraps below zero
//   value       - current count
//   zero        - high while the count is zero
module sweep_settle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load wins over decrement so a reload on the last sample cycle is never
    // lost; the count saturates at zero instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign value = count;
    assign zero  = (count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives every input vector into an external
// combinational circuit, waits a programmable settle time, samples the
// circuit output and compares the collected truth table with an expected one.
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   start, abort        - begin a sweep (IDLE only) / cancel a sweep
//   expected_tt         - expected truth table, bit i for vector i
//   settle_cycles       - wait cycles between driving a vector and sampling it
//   circuit_out         - response of the circuit under control
//   in1..in4            - circuit input drives (in1 = MSB of vector index)
//   busy, done          - sweep in progress / one-cycle completion pulse
//   pass                - observed table matched expected on the last sweep
//   observed_tt         - sampled responses, bit i for vector i
//   mismatch_mask       - observed_tt XOR expected_tt, valid from done onward
module truth_table_sweeper
    import cello_sweep_pkg::*;
#(
    parameter int SETTLE_W = 8,
    parameter int NUM_IN   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [(2**NUM_IN)-1:0] expected_tt,
    input  logic [SETTLE_W-1:0]    settle_cycles,
    input  logic                   circuit_out,
    output logic                   in1,
    output logic                   in2,
    output logic                   in3,
    output logic                   in4,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(2**NUM_IN)-1:0] observed_tt,
    output logic [(2**NUM_IN)-1:0] mismatch_mask
);

    localparam int NV = 2**NUM_IN;

    sweep_state_t        state, state_next;
    logic [NUM_IN-1:0]   idx;
    logic [NV-1:0]       expected_q;
    logic [NV-1:0]       obs_next;
    logic [SETTLE_W-1:0] settle_q;
    logic [SETTLE_W-1:0] timer_load_value;
    logic [SETTLE_W-1:0] timer_value;
    logic                timer_load;
    logic                timer_enable;
    logic                timer_zero;
    logic                accept;
    logic                last_vec;

    assign accept   = (state == ST_IDLE) && start && !abort;
    assign last_vec = (idx == NUM_IN'(NV - 1));

    sweep_settle_timer #(
        .WIDTH (SETTLE_W)
    ) u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (timer_load_value),
        .enable     (timer_enable),
        .value      (timer_value),
        .zero       (timer_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and settle-timer control. The first load of a sweep takes
    // settle_cycles straight from the port because the latched copy is only
    // written on the same edge; later reloads use the latched copy.
    always_comb begin
        state_next       = state;
        timer_load       = 1'b0;
        timer_enable     = 1'b0;
        timer_load_value = settle_q;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next       = ST_SETTLE;
                    timer_load       = 1'b1;
                    timer_load_value = settle_cycles;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (timer_zero) begin
                    state_next = ST_SAMPLE;
                end else begin
                    timer_enable = (timer_value != '0);
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (last_vec) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_SETTLE;
                    timer_load = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Observed table including the bit captured this cycle, so the final
    // verdict can be registered on the same edge that enters DONE.
    always_comb begin
        obs_next      = observed_tt;
        obs_next[idx] = circuit_out;
    end

    // Sweep datapath: vector index, latched configuration, captured table
    // and verdict. idx returns to zero on completion or abort so the circuit
    // inputs rest at 0000 outside a sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx           <= '0;
            expected_q    <= '0;
            settle_q      <= '0;
            observed_tt   <= '0;
            pass          <= 1'b0;
            mismatch_mask <= '0;
        end else if (state == ST_IDLE) begin
            if (accept) begin
                idx           <= '0;
                expected_q    <= expected_tt;
                settle_q      <= settle_cycles;
                observed_tt   <= '0;
                pass          <= 1'b0;
                mismatch_mask <= '0;
            end
        end else if (abort) begin
            idx           <= '0;
            pass          <= 1'b0;
            mismatch_mask <= '0;
        end else if (state == ST_SAMPLE) begin
            observed_tt <= obs_next;
            if (last_vec) begin
                idx           <= '0;
                pass          <= (obs_next == expected_q);
                mismatch_mask <= obs_next ^ expected_q;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign in1  = idx[IN1_BIT];
    assign in2  = idx[IN2_BIT];
    assign in3  = idx[IN3_BIT];
    assign in4  = idx[IN4_BIT];
    assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign done = (state == ST_DONE);

endmodule
